// File: rtl/usb_pkg.sv
// Shared types and constants for the USB transmit sequencer.
package usb_pkg;

  typedef enum logic [1:0] {
    HS    = 2'd0,
    TOKEN = 2'd1,
    DATA  = 2'd2,
    BAD   = 2'd3
  } pkt_kind_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_PID     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CRC     = 3'd4,
    ST_EOP     = 3'd5,
    ST_JIDLE   = 3'd6
  } tx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  localparam logic [6:0] SYNC_LEN  = 7'd8;
  localparam logic [6:0] PID_LEN   = 7'd8;
  localparam logic [6:0] TOK_LEN   = 7'd11;
  localparam logic [6:0] DATA_LEN  = 7'd64;
  localparam logic [6:0] CRC5_LEN  = 7'd5;
  localparam logic [6:0] CRC16_LEN = 7'd16;
  localparam logic [6:0] EOP_LEN   = 7'd2;

  // PID byte on the wire: check nibble (inverted PID) above the PID itself.
  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

  // Counter value of the last bit of a field of the given length.
  function automatic logic [6:0] last_idx(input logic [6:0] len);
    return len - 7'd1;
  endfunction

endpackage

// File: rtl/usb_tx_sequencer_if.sv
// Request and serial-path signals between requester, sequencer and stuffer.
interface usb_tx_sequencer_if;

  logic        pkt_req;
  logic [1:0]  pkt_kind;
  logic [3:0]  pkt_pid;
  logic [63:0] pkt_payload;
  logic [15:0] pkt_crc;
  logic        stuff_hold;
  logic        pkt_ack;
  logic        pkt_err;
  logic        bit_out;
  logic        bit_valid;
  logic        stuff_en;
  logic        eop;
  logic        busy;
  logic        done;

  modport master (
    output pkt_req, pkt_kind, pkt_pid, pkt_payload, pkt_crc, stuff_hold,
    input  pkt_ack, pkt_err, bit_out, bit_valid, stuff_en, eop, busy, done
  );

  modport slave (
    input  pkt_req, pkt_kind, pkt_pid, pkt_payload, pkt_crc, stuff_hold,
    output pkt_ack, pkt_err, bit_out, bit_valid, stuff_en, eop, busy, done
  );

endinterface

// File: rtl/usb_tx_sequencer.sv
// Packet-level transmit sequencer: SYNC, PID, payload and CRC sent LSB
// first into the bit-stuffer, followed by a two-cycle SE0 and one J cycle.
module usb_tx_sequencer
  import usb_pkg::*;
(
  input logic               clk,
  input logic               rst_b,
  usb_tx_sequencer_if.slave bus
);

  tx_state_t   state_r;
  tx_state_t   state_nxt_s;
  logic [6:0]  cnt_r;
  logic [6:0]  cnt_nxt_s;

  pkt_kind_t   kind_r;
  logic [3:0]  pid_r;
  logic [63:0] payload_r;
  logic [15:0] crc_r;

  pkt_kind_t   req_kind_s;
  logic        latch_s;
  logic        ack_nxt_s;
  logic        err_nxt_s;
  logic        done_nxt_s;
  logic        valid_nxt_s;
  logic        stuff_en_nxt_s;
  logic        eop_nxt_s;
  logic        busy_nxt_s;
  logic [6:0]  pay_last_s;
  logic [6:0]  crc_last_s;
  logic [7:0]  pid_byte_s;
  logic        bit_s;

  logic        pkt_ack_r;
  logic        pkt_err_r;
  logic        bit_valid_r;
  logic        stuff_en_r;
  logic        eop_r;
  logic        busy_r;
  logic        done_r;

  assign req_kind_s = pkt_kind_t'(bus.pkt_kind);
  assign pay_last_s = (kind_r == DATA) ? last_idx(DATA_LEN) : last_idx(TOK_LEN);
  assign crc_last_s = (kind_r == DATA) ? last_idx(CRC16_LEN) : last_idx(CRC5_LEN);
  assign pid_byte_s = pid_byte(pid_r);

  // Next state, bit counter and handshake pulses; stuff_hold freezes the stuffed fields.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    latch_s     = 1'b0;
    ack_nxt_s   = 1'b0;
    err_nxt_s   = 1'b0;
    done_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.pkt_req) begin
          ack_nxt_s = 1'b1;
          if (req_kind_s == BAD) begin
            err_nxt_s = 1'b1;
          end else begin
            latch_s     = 1'b1;
            state_nxt_s = ST_SYNC;
            cnt_nxt_s   = 7'd0;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SYNC: begin
        if (cnt_r == last_idx(SYNC_LEN)) begin
          state_nxt_s = ST_PID;
          cnt_nxt_s   = 7'd0;
        end else begin
          cnt_nxt_s = cnt_r + 7'd1;
        end
      end
      ST_PID: begin
        if (bus.stuff_hold) begin
          cnt_nxt_s = cnt_r;
        end else if (cnt_r == last_idx(PID_LEN)) begin
          state_nxt_s = (kind_r == HS) ? ST_EOP : ST_PAYLOAD;
          cnt_nxt_s   = 7'd0;
        end else begin
          cnt_nxt_s = cnt_r + 7'd1;
        end
      end
      ST_PAYLOAD: begin
        if (bus.stuff_hold) begin
          cnt_nxt_s = cnt_r;
        end else if (cnt_r == pay_last_s) begin
          state_nxt_s = ST_CRC;
          cnt_nxt_s   = 7'd0;
        end else begin
          cnt_nxt_s = cnt_r + 7'd1;
        end
      end
      ST_CRC: begin
        if (bus.stuff_hold) begin
          cnt_nxt_s = cnt_r;
        end else if (cnt_r == crc_last_s) begin
          state_nxt_s = ST_EOP;
          cnt_nxt_s   = 7'd0;
        end else begin
          cnt_nxt_s = cnt_r + 7'd1;
        end
      end
      ST_EOP: begin
        if (cnt_r == last_idx(EOP_LEN)) begin
          state_nxt_s = ST_JIDLE;
          cnt_nxt_s   = 7'd0;
        end else begin
          cnt_nxt_s = cnt_r + 7'd1;
        end
      end
      ST_JIDLE: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 7'd0;
        done_nxt_s  = 1'b1;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 7'd0;
      end
    endcase
  end

  // Serial status flags decoded from the upcoming state so they register in step with it.
  always_comb begin
    valid_nxt_s    = 1'b0;
    stuff_en_nxt_s = 1'b0;
    eop_nxt_s      = 1'b0;
    busy_nxt_s     = 1'b1;
    case (state_nxt_s)
      ST_IDLE:    busy_nxt_s = 1'b0;
      ST_SYNC:    valid_nxt_s = 1'b1;
      ST_PID,
      ST_PAYLOAD,
      ST_CRC: begin
        valid_nxt_s    = 1'b1;
        stuff_en_nxt_s = 1'b1;
      end
      ST_EOP:     eop_nxt_s = 1'b1;
      ST_JIDLE:   busy_nxt_s = 1'b1;
      default:    busy_nxt_s = 1'b0;
    endcase
  end

  // Current serial bit, selected from the latched fields by state and counter.
  always_comb begin
    bit_s = 1'b0;
    case (state_r)
      ST_SYNC:    bit_s = SYNC_BYTE[cnt_r[2:0]];
      ST_PID:     bit_s = pid_byte_s[cnt_r[2:0]];
      ST_PAYLOAD: bit_s = payload_r[cnt_r[5:0]];
      ST_CRC:     bit_s = crc_r[cnt_r[3:0]];
      default:    bit_s = 1'b0;
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 7'd0;
      pkt_ack_r   <= 1'b0;
      pkt_err_r   <= 1'b0;
      bit_valid_r <= 1'b0;
      stuff_en_r  <= 1'b0;
      eop_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      pkt_ack_r   <= ack_nxt_s;
      pkt_err_r   <= err_nxt_s;
      bit_valid_r <= valid_nxt_s;
      stuff_en_r  <= stuff_en_nxt_s;
      eop_r       <= eop_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  // Packet fields captured on acceptance so requester changes cannot reach bits in flight.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      kind_r    <= HS;
      pid_r     <= 4'd0;
      payload_r <= 64'd0;
      crc_r     <= 16'd0;
    end else if (latch_s) begin
      kind_r    <= req_kind_s;
      pid_r     <= bus.pkt_pid;
      payload_r <= bus.pkt_payload;
      crc_r     <= bus.pkt_crc;
    end else begin
      kind_r    <= kind_r;
      pid_r     <= pid_r;
      payload_r <= payload_r;
      crc_r     <= crc_r;
    end
  end

  assign bus.pkt_ack   = pkt_ack_r;
  assign bus.pkt_err   = pkt_err_r;
  assign bus.bit_out   = bit_s;
  assign bus.bit_valid = bit_valid_r;
  assign bus.stuff_en  = stuff_en_r;
  assign bus.eop       = eop_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed bench for usb_tx_sequencer: field order, hold timing, illegal
// kind, mid-packet reset and back-to-back requests.
module tb_usb_tx_sequencer;

  logic clk = 1'b0;
  logic rst_b;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [15:0] head;

  usb_tx_sequencer_if bus();

  usb_tx_sequencer dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs_vec();
    return {bus.pkt_ack, bus.pkt_err, bus.bit_valid, bus.bit_out,
            bus.stuff_en, bus.eop, bus.busy, bus.done};
  endfunction

  function automatic logic [7:0] vec(input logic a, input logic e, input logic v,
                                     input logic b, input logic s, input logic p,
                                     input logic y, input logic d);
    return {a, e, v, b, s, p, y, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one packet and check every cycle up to done (or up to a planted reset).
  task automatic send(input string tag, input logic [1:0] kind, input logic [3:0] pid,
                      input logic [63:0] pay, input logic [15:0] crc,
                      input int hold_at, input int abort_at, input bit keep_req,
                      input int exp_cyc, output logic [15:0] hd);
    logic eb [0:95];
    logic es [0:95];
    int   nbits, npay, ncrc, idx, cyc;
    bit   held;
    nbits = 0;
    for (int i = 0; i < 8; i++) begin eb[nbits] = (i == 7); es[nbits] = 1'b0; nbits++; end
    for (int i = 0; i < 4; i++) begin eb[nbits] = pid[i];   es[nbits] = 1'b1; nbits++; end
    for (int i = 0; i < 4; i++) begin eb[nbits] = ~pid[i];  es[nbits] = 1'b1; nbits++; end
    npay = (kind == 2'd2) ? 64 : ((kind == 2'd1) ? 11 : 0);
    ncrc = (kind == 2'd2) ? 16 : ((kind == 2'd1) ? 5 : 0);
    for (int i = 0; i < npay; i++) begin eb[nbits] = pay[i]; es[nbits] = 1'b1; nbits++; end
    for (int i = 0; i < ncrc; i++) begin eb[nbits] = crc[i]; es[nbits] = 1'b1; nbits++; end

    bus.pkt_kind    = kind;
    bus.pkt_pid     = pid;
    bus.pkt_payload = pay;
    bus.pkt_crc     = crc;
    bus.pkt_req     = 1'b1;
    tick();
    // Change every request input while the packet is in flight.
    bus.pkt_kind    = ~kind;
    bus.pkt_pid     = ~pid;
    bus.pkt_payload = ~pay;
    bus.pkt_crc     = ~crc;
    bus.pkt_req     = keep_req;

    hd = 16'd0; idx = 0; cyc = 0; held = 1'b0;
    while (idx < nbits) begin
      chk($sformatf("%s_bit%0d", tag, idx), 64'(obs_vec()),
          64'(vec(cyc == 0, 1'b0, 1'b1, eb[idx], es[idx], 1'b0, 1'b1, 1'b0)));
      if (idx < 16) hd[idx] = bus.bit_out;
      if (idx == abort_at) begin
        #2 rst_b = 1'b0;
        #1;
        chk($sformatf("%s_reset_outputs", tag), 64'(obs_vec()), 64'd0);
        bus.pkt_req = 1'b0;
        tick();
        rst_b = 1'b1;
        tick();
        chk($sformatf("%s_after_release", tag), 64'(obs_vec()), 64'd0);
        return;
      end
      if (idx == hold_at && !held) begin
        bus.stuff_hold = 1'b1;
        held = 1'b1;
        tick();
        bus.stuff_hold = 1'b0;
      end else begin
        tick();
        idx++;
      end
      cyc++;
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_eop%0d", tag, k), 64'(obs_vec()),
          64'(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)));
      tick();
      cyc++;
    end
    chk($sformatf("%s_jidle", tag), 64'(obs_vec()),
        64'(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)));
    tick();
    cyc++;
    chk($sformatf("%s_done", tag), 64'(obs_vec()),
        64'(vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)));
    chk($sformatf("%s_ack_to_done", tag), 64'(cyc), 64'(exp_cyc));
  endtask

  initial begin
    rst_b           = 1'b0;
    bus.pkt_req     = 1'b0;
    bus.pkt_kind    = 2'd0;
    bus.pkt_pid     = 4'd0;
    bus.pkt_payload = 64'd0;
    bus.pkt_crc     = 16'd0;
    bus.stuff_hold  = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", 64'(obs_vec()), 64'd0);
    rst_b = 1'b1;
    tick();
    chk("idle_after_reset", 64'(obs_vec()), 64'd0);

    // Handshake, PID 2: SYNC 0000000 1 then 0100 1011 on the wire.
    send("hs", 2'd0, 4'h2, 64'd0, 16'd0, -1, -1, 1'b0, 19, head);
    chk("hs_wire_bits", 64'(head), 64'(16'hD280));
    tick();

    // Token, one hold cycle on payload bit 4 (stream index 20).
    send("tok", 2'd1, 4'h9, 64'h7FF, 16'h001F, 20, -1, 1'b0, 36, head);
    chk("tok_wire_bits", 64'(head), 64'(16'h6980));
    tick();

    // Data, all ones, hold on the last CRC bit (stream index 95).
    send("data", 2'd2, 4'h3, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF, 95, -1, 1'b0, 100, head);
    tick();

    // Illegal kind: ack and err together, nothing transmitted.
    bus.pkt_kind = 2'd3;
    bus.pkt_req  = 1'b1;
    tick();
    chk("bad_ack_err", 64'(obs_vec()),
        64'(vec(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
    bus.pkt_req = 1'b0;
    tick();
    chk("bad_after", 64'(obs_vec()), 64'd0);
    tick();
    chk("bad_idle", 64'(obs_vec()), 64'd0);

    // Reset during data payload bit 30 (stream index 46), then a fresh packet.
    send("rst", 2'd2, 4'hC, 64'h0123_4567_89AB_CDEF, 16'hBEEF, -1, 46, 1'b0, 0, head);
    send("post_rst", 2'd0, 4'hA, 64'd0, 16'd0, -1, -1, 1'b0, 19, head);
    chk("post_rst_wire_bits", 64'(head), 64'(16'h5A80));
    tick();

    // Request held high across two packets: second ack one cycle after done.
    send("keep1", 2'd1, 4'h1, 64'h5A5, 16'h0015, -1, -1, 1'b1, 35, head);
    send("keep2", 2'd0, 4'hB, 64'd0, 16'd0, -1, -1, 1'b0, 19, head);
    chk("keep2_wire_bits", 64'(head), 64'(16'h4B80));
    tick();
    chk("final_idle", 64'(obs_vec()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
